rvfi_retire_packer: RTL and testbench

Parametrised RVFI retirement packer between the hart's single-record retirement stream and the formal RVFI port bundle. It collects retired-instruction records into groups of up to NRET, assigns `order` numbers, and drives NRET-lane RVFI outputs with registered timing. Partial groups are flushed on idle timeout, trap or halt. It replaces direct one-to-one RVFI port hookup when the checker harness runs with NRET > 1.

---
 rtl/rvfi_pkg.sv | 51 +++++
 rtl/rvfi_pack_buf.sv | 68 ++++++
 rtl/rvfi_retire_packer.sv | 169 ++++++++++++++++
 tb/tb_rvfi_retire_packer.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rvfi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rvfi_pkg
// Description : Shared types and widths for the RVFI retirement packer.
//               One retirement record (rvfi_rec_t) carries every per-
//               instruction RVFI field except valid and order, which the
//               packer generates itself.
// Revision    : 1.0 - initial release
// ============================================================================
package rvfi_pkg;

    // Record geometry. The packer's XLEN/ILEN parameters must match these.
    localparam int RVFI_XLEN  = 32;
    localparam int RVFI_ILEN  = 32;
    localparam int MASK_W     = RVFI_XLEN / 8;
    localparam int REG_ADDR_W = 5;
    localparam int MODE_W     = 2;
    localparam int IXL_W      = 2;
    localparam int ORDER_W    = 64;
    localparam int IDLE_W     = 8;

    typedef struct packed {
        logic [RVFI_ILEN-1:0]  insn;
        logic                  trap;
        logic                  halt;
        logic                  intr;
        logic [MODE_W-1:0]     mode;
        logic [IXL_W-1:0]      ixl;
        logic [REG_ADDR_W-1:0] rs1_addr;
        logic [REG_ADDR_W-1:0] rs2_addr;
        logic [RVFI_XLEN-1:0]  rs1_rdata;
        logic [RVFI_XLEN-1:0]  rs2_rdata;
        logic [REG_ADDR_W-1:0] rd_addr;
        logic [RVFI_XLEN-1:0]  rd_wdata;
        logic [RVFI_XLEN-1:0]  pc_rdata;
        logic [RVFI_XLEN-1:0]  pc_wdata;
        logic [RVFI_XLEN-1:0]  mem_addr;
        logic [MASK_W-1:0]     mem_rmask;
        logic [MASK_W-1:0]     mem_wmask;
        logic [RVFI_XLEN-1:0]  mem_rdata;
        logic [RVFI_XLEN-1:0]  mem_wdata;
    } rvfi_rec_t;

    // A trap or halt closes the current group early so the checker sees it
    // without waiting for the group to fill.
    function automatic logic rec_flush_trigger(input rvfi_rec_t rec);
        return rec.trap | rec.halt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rvfi_pack_buf.sv
`default_nettype none
// ============================================================================
// Module      : rvfi_pack_buf
// Description : Group buffer for the retirement packer: NRET record slots,
//               fill count and idle counter.
// Ports       : clock, reset_n (async active-low)
//               wr_en/wr_rec  - record accepted this cycle
//               emit          - current group leaves this cycle
//               slots         - buffered records, slot 0 oldest
//               count         - number of valid slots (0..NRET)
//               idle_cnt      - cycles without accept/emit while non-empty
// Revision    : 1.0 - initial release
// ============================================================================
module rvfi_pack_buf
    import rvfi_pkg::*;
#(
    parameter int NRET  = 2,
    parameter int CNT_W = $clog2(NRET + 1)
) (
    input  wire logic              clock,
    input  wire logic              reset_n,
    input  wire logic              wr_en,
    input  wire rvfi_rec_t         wr_rec,
    input  wire logic              emit,
    output rvfi_rec_t              slots [NRET],
    output logic [CNT_W-1:0]       count,
    output logic [IDLE_W-1:0]      idle_cnt
);

    rvfi_rec_t          r_slots [NRET];
    logic [CNT_W-1:0]   r_count;
    logic [IDLE_W-1:0]  r_idle;

    // Slot payload needs no reset: only slots below count are ever observed.
    // On an emit edge the group is leaving, so a new record restarts at slot 0.
    for (genvar s = 0; s < NRET; s++) begin : g_slot
        always_ff @(posedge clock) begin
            if (wr_en && (emit ? (s == 0) : (r_count == CNT_W'(s)))) begin
                r_slots[s] <= wr_rec;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
            r_idle  <= '0;
        end else begin
            if (emit) begin
                r_count <= wr_en ? CNT_W'(1) : '0;
            end else if (wr_en) begin
                r_count <= r_count + 1'b1;
            end

            if (wr_en || emit) begin
                r_idle <= '0;
            end else if ((r_count != '0) && (r_idle != '1)) begin
                r_idle <= r_idle + 1'b1;
            end
        end
    end

    assign slots    = r_slots;
    assign count    = r_count;
    assign idle_cnt = r_idle;

endmodule
`default_nettype wire

// File: rtl/rvfi_retire_packer.sv
`default_nettype none
// ============================================================================
// Module      : rvfi_retire_packer
// Description : Packs a single-record retirement stream into NRET-lane RVFI
//               outputs. Groups leave when full, after FLUSH_CYCLES idle
//               cycles, or as soon as the newest record traps or halts.
//               Each lane carries order = running count of retired records.
// Ports       : clock, reset_n (async active-low)
//               in_valid/in_ready/in_rec - retirement record handshake
//               rvfi_*                   - registered NRET-lane RVFI bundle,
//                                          lane i at [i*W +: W]
//               halted                   - sticky, a halt record was emitted
// Revision    : 1.0 - initial release
// ============================================================================
module rvfi_retire_packer
    import rvfi_pkg::*;
#(
    parameter int NRET         = 2,
    parameter int XLEN         = RVFI_XLEN,
    parameter int ILEN         = RVFI_ILEN,
    parameter int FLUSH_CYCLES = 4
) (
    input  wire logic                     clock,
    input  wire logic                     reset_n,
    input  wire logic                     in_valid,
    output logic                          in_ready,
    input  wire rvfi_rec_t                in_rec,
    output logic [NRET-1:0]               rvfi_valid,
    output logic [NRET*ORDER_W-1:0]       rvfi_order,
    output logic [NRET*ILEN-1:0]          rvfi_insn,
    output logic [NRET-1:0]               rvfi_trap,
    output logic [NRET-1:0]               rvfi_halt,
    output logic [NRET-1:0]               rvfi_intr,
    output logic [NRET*MODE_W-1:0]        rvfi_mode,
    output logic [NRET*IXL_W-1:0]         rvfi_ixl,
    output logic [NRET*REG_ADDR_W-1:0]    rvfi_rs1_addr,
    output logic [NRET*REG_ADDR_W-1:0]    rvfi_rs2_addr,
    output logic [NRET*XLEN-1:0]          rvfi_rs1_rdata,
    output logic [NRET*XLEN-1:0]          rvfi_rs2_rdata,
    output logic [NRET*REG_ADDR_W-1:0]    rvfi_rd_addr,
    output logic [NRET*XLEN-1:0]          rvfi_rd_wdata,
    output logic [NRET*XLEN-1:0]          rvfi_pc_rdata,
    output logic [NRET*XLEN-1:0]          rvfi_pc_wdata,
    output logic [NRET*XLEN-1:0]          rvfi_mem_addr,
    output logic [NRET*(XLEN/8)-1:0]      rvfi_mem_rmask,
    output logic [NRET*(XLEN/8)-1:0]      rvfi_mem_wmask,
    output logic [NRET*XLEN-1:0]          rvfi_mem_rdata,
    output logic [NRET*XLEN-1:0]          rvfi_mem_wdata,
    output logic                          halted
);

    localparam int CNT_W = $clog2(NRET + 1);

    rvfi_rec_t          w_slots [NRET];
    logic [CNT_W-1:0]   w_count;
    logic [IDLE_W-1:0]  w_idle;
    logic               w_accept;
    logic               w_emit;
    logic               w_last_flush;
    logic               w_emit_halt;

    rvfi_rec_t          r_lane_rec   [NRET];
    logic [ORDER_W-1:0] r_lane_order [NRET];
    logic [NRET-1:0]    r_valid;
    logic [ORDER_W-1:0] r_order_base;
    logic               r_halted;
    logic               r_halt_pending;

    // Once a halt is buffered nothing more may enter: the halt must be the
    // final record the checker ever sees.
    assign in_ready = !r_halted && !r_halt_pending;
    assign w_accept = in_valid && in_ready;

    rvfi_pack_buf #(
        .NRET   (NRET),
        .CNT_W  (CNT_W)
    ) u_buf (
        .clock    (clock),
        .reset_n  (reset_n),
        .wr_en    (w_accept),
        .wr_rec   (in_rec),
        .emit     (w_emit),
        .slots    (w_slots),
        .count    (w_count),
        .idle_cnt (w_idle)
    );

    always_comb begin
        w_last_flush = 1'b0;
        w_emit_halt  = 1'b0;
        for (int i = 0; i < NRET; i++) begin
            if (CNT_W'(i + 1) == w_count) begin
                w_last_flush = rec_flush_trigger(w_slots[i]);
            end
            if (CNT_W'(i) < w_count) begin
                w_emit_halt = w_emit_halt | w_slots[i].halt;
            end
        end
    end

    // A full buffer always emits, which is what lets an accept land on the
    // same edge without stalling the hart.
    assign w_emit = (w_count == CNT_W'(NRET)) ||
                    ((w_count != '0) &&
                     ((int'(w_idle) >= FLUSH_CYCLES) || w_last_flush));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_valid        <= '0;
            r_order_base   <= '0;
            r_halted       <= 1'b0;
            r_halt_pending <= 1'b0;
            for (int i = 0; i < NRET; i++) begin
                r_lane_rec[i]   <= '0;
                r_lane_order[i] <= '0;
            end
        end else begin
            r_valid <= '0;
            if (w_emit) begin
                for (int i = 0; i < NRET; i++) begin
                    if (CNT_W'(i) < w_count) begin
                        r_valid[i]      <= 1'b1;
                        r_lane_rec[i]   <= w_slots[i];
                        r_lane_order[i] <= r_order_base + ORDER_W'(i);
                    end else begin
                        r_lane_rec[i]   <= '0;
                        r_lane_order[i] <= '0;
                    end
                end
                r_order_base <= r_order_base + ORDER_W'(w_count);
                if (w_emit_halt) begin
                    r_halted       <= 1'b1;
                    r_halt_pending <= 1'b0;
                end
            end
            if (w_accept && in_rec.halt) begin
                r_halt_pending <= 1'b1;
            end
        end
    end

    assign rvfi_valid = r_valid;
    assign halted     = r_halted;

    for (genvar l = 0; l < NRET; l++) begin : g_lane
        assign rvfi_order    [l*ORDER_W    +: ORDER_W]    = r_lane_order[l];
        assign rvfi_insn     [l*ILEN       +: ILEN]       = r_lane_rec[l].insn;
        assign rvfi_trap     [l]                          = r_lane_rec[l].trap;
        assign rvfi_halt     [l]                          = r_lane_rec[l].halt;
        assign rvfi_intr     [l]                          = r_lane_rec[l].intr;
        assign rvfi_mode     [l*MODE_W     +: MODE_W]     = r_lane_rec[l].mode;
        assign rvfi_ixl      [l*IXL_W      +: IXL_W]      = r_lane_rec[l].ixl;
        assign rvfi_rs1_addr [l*REG_ADDR_W +: REG_ADDR_W] = r_lane_rec[l].rs1_addr;
        assign rvfi_rs2_addr [l*REG_ADDR_W +: REG_ADDR_W] = r_lane_rec[l].rs2_addr;
        assign rvfi_rs1_rdata[l*XLEN       +: XLEN]       = r_lane_rec[l].rs1_rdata;
        assign rvfi_rs2_rdata[l*XLEN       +: XLEN]       = r_lane_rec[l].rs2_rdata;
        assign rvfi_rd_addr  [l*REG_ADDR_W +: REG_ADDR_W] = r_lane_rec[l].rd_addr;
        assign rvfi_rd_wdata [l*XLEN       +: XLEN]       = r_lane_rec[l].rd_wdata;
        assign rvfi_pc_rdata [l*XLEN       +: XLEN]       = r_lane_rec[l].pc_rdata;
        assign rvfi_pc_wdata [l*XLEN       +: XLEN]       = r_lane_rec[l].pc_wdata;
        assign rvfi_mem_addr [l*XLEN       +: XLEN]       = r_lane_rec[l].mem_addr;
        assign rvfi_mem_rmask[l*(XLEN/8)   +: XLEN/8]     = r_lane_rec[l].mem_rmask;
        assign rvfi_mem_wmask[l*(XLEN/8)   +: XLEN/8]     = r_lane_rec[l].mem_wmask;
        assign rvfi_mem_rdata[l*XLEN       +: XLEN]       = r_lane_rec[l].mem_rdata;
        assign rvfi_mem_wdata[l*XLEN       +: XLEN]       = r_lane_rec[l].mem_wdata;
    end

endmodule
`default_nettype wire

// File: tb/tb_rvfi_retire_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_rvfi_retire_packer
// Description : Self-checking bench for rvfi_retire_packer (NRET=2,
//               FLUSH_CYCLES=4). A queue-based reference model predicts the
//               RVFI bundle every cycle; directed scenarios add literal
//               expectations on group timing and order numbers.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rvfi_retire_packer;
    import rvfi_pkg::*;

    localparam int NRET  = 2;
    localparam int XLEN  = RVFI_XLEN;
    localparam int ILEN  = RVFI_ILEN;
    localparam int FLUSH = 4;

    logic                        clock   = 1'b0;
    logic                        reset_n = 1'b1;
    logic                        in_valid = 1'b0;
    logic                        in_ready;
    rvfi_rec_t                   in_rec = '0;
    logic [NRET-1:0]             rvfi_valid;
    logic [NRET*ORDER_W-1:0]     rvfi_order;
    logic [NRET*ILEN-1:0]        rvfi_insn;
    logic [NRET-1:0]             rvfi_trap, rvfi_halt, rvfi_intr;
    logic [NRET*MODE_W-1:0]      rvfi_mode;
    logic [NRET*IXL_W-1:0]       rvfi_ixl;
    logic [NRET*REG_ADDR_W-1:0]  rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr;
    logic [NRET*XLEN-1:0]        rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata;
    logic [NRET*XLEN-1:0]        rvfi_pc_rdata, rvfi_pc_wdata, rvfi_mem_addr;
    logic [NRET*XLEN-1:0]        rvfi_mem_rdata, rvfi_mem_wdata;
    logic [NRET*(XLEN/8)-1:0]    rvfi_mem_rmask, rvfi_mem_wmask;
    logic                        halted;

    always #5 clock = ~clock;

    rvfi_retire_packer #(
        .NRET(NRET), .XLEN(XLEN), .ILEN(ILEN), .FLUSH_CYCLES(FLUSH)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_rec(in_rec),
        .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order), .rvfi_insn(rvfi_insn),
        .rvfi_trap(rvfi_trap), .rvfi_halt(rvfi_halt), .rvfi_intr(rvfi_intr),
        .rvfi_mode(rvfi_mode), .rvfi_ixl(rvfi_ixl),
        .rvfi_rs1_addr(rvfi_rs1_addr), .rvfi_rs2_addr(rvfi_rs2_addr),
        .rvfi_rs1_rdata(rvfi_rs1_rdata), .rvfi_rs2_rdata(rvfi_rs2_rdata),
        .rvfi_rd_addr(rvfi_rd_addr), .rvfi_rd_wdata(rvfi_rd_wdata),
        .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata),
        .rvfi_mem_addr(rvfi_mem_addr), .rvfi_mem_rmask(rvfi_mem_rmask),
        .rvfi_mem_wmask(rvfi_mem_wmask), .rvfi_mem_rdata(rvfi_mem_rdata),
        .rvfi_mem_wdata(rvfi_mem_wdata), .halted(halted)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic rvfi_rec_t rand_rec();
        logic [$bits(rvfi_rec_t)-1:0] v;
        rvfi_rec_t r;
        for (int k = 0; k < $bits(rvfi_rec_t); k++) v[k] = 1'($urandom_range(0, 1));
        r      = rvfi_rec_t'(v);
        r.halt = 1'b0;
        r.trap = ($urandom_range(0, 15) == 0);
        return r;
    endfunction

    function automatic rvfi_rec_t lane_rec(input int i);
        rvfi_rec_t r;
        r.insn      = rvfi_insn[i*ILEN +: ILEN];
        r.trap      = rvfi_trap[i];
        r.halt      = rvfi_halt[i];
        r.intr      = rvfi_intr[i];
        r.mode      = rvfi_mode[i*MODE_W +: MODE_W];
        r.ixl       = rvfi_ixl[i*IXL_W +: IXL_W];
        r.rs1_addr  = rvfi_rs1_addr[i*REG_ADDR_W +: REG_ADDR_W];
        r.rs2_addr  = rvfi_rs2_addr[i*REG_ADDR_W +: REG_ADDR_W];
        r.rs1_rdata = rvfi_rs1_rdata[i*XLEN +: XLEN];
        r.rs2_rdata = rvfi_rs2_rdata[i*XLEN +: XLEN];
        r.rd_addr   = rvfi_rd_addr[i*REG_ADDR_W +: REG_ADDR_W];
        r.rd_wdata  = rvfi_rd_wdata[i*XLEN +: XLEN];
        r.pc_rdata  = rvfi_pc_rdata[i*XLEN +: XLEN];
        r.pc_wdata  = rvfi_pc_wdata[i*XLEN +: XLEN];
        r.mem_addr  = rvfi_mem_addr[i*XLEN +: XLEN];
        r.mem_rmask = rvfi_mem_rmask[i*(XLEN/8) +: XLEN/8];
        r.mem_wmask = rvfi_mem_wmask[i*(XLEN/8) +: XLEN/8];
        r.mem_rdata = rvfi_mem_rdata[i*XLEN +: XLEN];
        r.mem_wdata = rvfi_mem_wdata[i*XLEN +: XLEN];
        return r;
    endfunction

    // ---------------- reference model ----------------
    rvfi_rec_t       m_q [$];
    int              m_idle   = 0;
    logic [63:0]     m_order  = '0;
    bit              m_halted = 1'b0;
    bit              m_hpend  = 1'b0;
    logic [NRET-1:0] e_valid  = '0;
    logic [63:0]     e_order [NRET] = '{default: '0};
    rvfi_rec_t       e_rec   [NRET] = '{default: '0};
    int              m_n;
    bit              m_acc, m_emit, m_hh;

    always @(posedge clock) cyc <= cyc + 1;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_q.delete();
            m_idle   = 0;
            m_order  = '0;
            m_halted = 1'b0;
            m_hpend  = 1'b0;
            e_valid  = '0;
            for (int i = 0; i < NRET; i++) begin
                e_order[i] = '0;
                e_rec[i]   = '0;
            end
        end else begin
            m_acc  = in_valid && !m_halted && !m_hpend;
            m_n    = m_q.size();
            m_emit = (m_n == NRET) ||
                     (m_n > 0 && (m_idle >= FLUSH || m_q[m_n-1].trap || m_q[m_n-1].halt));
            e_valid = '0;
            if (m_emit) begin
                m_hh = 1'b0;
                for (int i = 0; i < NRET; i++) begin
                    if (i < m_n) begin
                        e_valid[i] = 1'b1;
                        e_rec[i]   = m_q[i];
                        e_order[i] = m_order + 64'(i);
                        if (m_q[i].halt) m_hh = 1'b1;
                    end else begin
                        e_rec[i]   = '0;
                        e_order[i] = '0;
                    end
                end
                m_order = m_order + 64'(m_n);
                m_q.delete();
                if (m_hh) begin
                    m_halted = 1'b1;
                    m_hpend  = 1'b0;
                end
            end
            if (m_acc) begin
                m_q.push_back(in_rec);
                if (in_rec.halt) m_hpend = 1'b1;
            end
            if (m_acc || m_emit) m_idle = 0;
            else if (m_n > 0 && m_idle < 255) m_idle++;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clock) begin
        if (reset_n) begin
            chk("valid", rvfi_valid, e_valid);
            chk("halted", halted, m_halted);
            chk("in_ready", in_ready, !m_halted && !m_hpend);
            for (int i = 0; i < NRET; i++) begin
                chk($sformatf("lane%0d_order", i), rvfi_order[i*64 +: 64], e_order[i]);
                chk($sformatf("lane%0d_fields", i), lane_rec(i), e_rec[i]);
            end
        end
    end

    // ---------------- emission log for directed checks ----------------
    typedef struct {
        int              c;
        logic [NRET-1:0] v;
        logic [63:0]     o0;
        logic [63:0]     o1;
        rvfi_rec_t       r1;
    } ev_t;
    ev_t evq [$];

    always @(negedge clock) begin
        if (reset_n && rvfi_valid != '0)
            evq.push_back('{cyc, rvfi_valid, rvfi_order[63:0], rvfi_order[127:64], lane_rec(1)});
    end

    task automatic send(input rvfi_rec_t r, output int acc);
        chk("send_ready", in_ready, 1'b1);
        in_valid = 1'b1;
        in_rec   = r;
        @(posedge clock);
        #1 acc = cyc;
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    int        t [4];
    rvfi_rec_t r;

    initial begin
        #2 reset_n = 1'b0;
        repeat (2) @(negedge clock);
        chk("rst_valid", rvfi_valid, 0);
        chk("rst_order", rvfi_order, 0);
        chk("rst_insn", rvfi_insn, 0);
        chk("rst_halted", halted, 0);
        reset_n = 1'b1;
        @(negedge clock);
        chk("rst_ready", in_ready, 1);

        // back-to-back A,B,C,D: two full groups, orders 0..3
        evq.delete();
        for (int k = 0; k < 4; k++) begin
            r = rand_rec(); r.trap = 1'b0;
            send(r, t[k]);
        end
        idle(12);
        chk("abcd_groups", evq.size(), 2);
        if (evq.size() >= 2) begin
            chk("abcd_cyc0", evq[0].c, t[1] + 1);
            chk("abcd_cyc1", evq[1].c, t[3] + 1);
            chk("abcd_v0", evq[0].v, 2'b11);
            chk("abcd_v1", evq[1].v, 2'b11);
            chk("abcd_o00", evq[0].o0, 0);
            chk("abcd_o01", evq[0].o1, 1);
            chk("abcd_o10", evq[1].o0, 2);
            chk("abcd_o11", evq[1].o1, 3);
        end

        // lone record: flushed FLUSH+1 cycles after accept, lane 1 zero
        evq.delete();
        r = rand_rec(); r.trap = 1'b0;
        send(r, t[0]);
        idle(12);
        chk("lone_groups", evq.size(), 1);
        if (evq.size() >= 1) begin
            chk("lone_cyc", evq[0].c, t[0] + 5);
            chk("lone_v", evq[0].v, 2'b01);
            chk("lone_o0", evq[0].o0, 4);
            chk("lone_o1", evq[0].o1, 0);
            chk("lone_l1", evq[0].r1, 0);
        end

        // trap first of group: emitted alone next cycle, follower order+1
        evq.delete();
        r = rand_rec(); r.trap = 1'b1;
        send(r, t[0]);
        r = rand_rec(); r.trap = 1'b0;
        send(r, t[1]);
        idle(12);
        chk("trap_groups", evq.size(), 2);
        if (evq.size() >= 2) begin
            chk("trap_cyc", evq[0].c, t[0] + 1);
            chk("trap_v", evq[0].v, 2'b01);
            chk("trap_o0", evq[0].o0, 5);
            chk("trap_next_o0", evq[1].o0, 6);
            chk("trap_next_cyc", evq[1].c, t[1] + 5);
        end

        // randomized traffic with alternating load
        for (int ph = 0; ph < 10; ph++) begin
            for (int k = 0; k < 200; k++) begin
                in_valid = (ph % 2 == 0) ? ($urandom_range(0, 3) != 0)
                                         : ($urandom_range(0, 3) == 0);
                in_rec   = rand_rec();
                @(negedge clock);
            end
        end
        in_valid = 1'b0;
        idle(12);

        // order wrap at 2^64
        force dut.r_order_base = 64'hFFFF_FFFF_FFFF_FFFF;
        m_order = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clock);
        release dut.r_order_base;
        evq.delete();
        r = rand_rec(); r.trap = 1'b0;
        send(r, t[0]);
        r = rand_rec(); r.trap = 1'b0;
        send(r, t[1]);
        idle(6);
        chk("wrap_groups", evq.size(), 1);
        if (evq.size() >= 1) begin
            chk("wrap_v", evq[0].v, 2'b11);
            chk("wrap_o0", evq[0].o0, 64'hFFFF_FFFF_FFFF_FFFF);
            chk("wrap_o1", evq[0].o1, 0);
        end

        // reset with one record buffered
        r = rand_rec(); r.trap = 1'b0;
        send(r, t[0]);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", rvfi_valid, 0);
        chk("mid_rst_order", rvfi_order, 0);
        chk("mid_rst_insn", rvfi_insn, 0);
        chk("mid_rst_pc", rvfi_pc_wdata, 0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        evq.delete();
        r = rand_rec(); r.trap = 1'b0;
        send(r, t[0]);
        idle(10);
        chk("post_rst_groups", evq.size(), 1);
        if (evq.size() >= 1) chk("post_rst_o0", evq[0].o0, 0);

        // halt: in_ready drops after accept, halted is sticky
        evq.delete();
        r = rand_rec(); r.trap = 1'b0; r.halt = 1'b1;
        send(r, t[0]);
        chk("halt_ready_drop", in_ready, 0);
        for (int k = 0; k < 6; k++) begin
            in_valid = 1'b1;
            in_rec   = rand_rec();
            @(negedge clock);
        end
        in_valid = 1'b0;
        idle(8);
        chk("halt_groups", evq.size(), 1);
        if (evq.size() >= 1) begin
            chk("halt_cyc", evq[0].c, t[0] + 1);
            chk("halt_v", evq[0].v, 2'b01);
            chk("halt_o0", evq[0].o0, 1);
        end
        chk("halt_sticky", halted, 1);
        chk("halt_ready_low", in_ready, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
